// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit_pkg : shared widths, reset vector and FIFO entry    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package instr_fetch_unit_pkg;

  localparam int C_INSTR_W = 16;
  localparam int C_ADDR_W  = 16;
  localparam logic [C_ADDR_W-1:0] C_RESET_VECTOR = 16'h0000;

  typedef struct packed {
    logic [C_ADDR_W-1:0]  pc;
    logic [C_INSTR_W-1:0] instr;
  } ifu_entry_t;

  function automatic logic [C_ADDR_W-1:0] next_pc(input logic [C_ADDR_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fifo : synchronous prefetch FIFO of {pc, instr} entries          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifu_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  ifu_entry_t            i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [DEPTH_LOG2:0]   o_count,
  output ifu_entry_t            o_head
);

  localparam int                    C_DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2+1)'(1);

  ifu_entry_t              r_mem [C_DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the head reads zero before the first fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit : PC, ROM issue/capture and prefetch FIFO handoff   |
// | Optional macro IFU_PERF_CNT_EN builds fetch/flush counters.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [C_ADDR_W-1:0] RESET_VEC  = C_RESET_VECTOR,
  parameter int                  DEPTH_LOG2 = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic [C_ADDR_W-1:0]  o_rom_addr,
  input  logic [C_INSTR_W-1:0] i_rom_data,
  input  logic                 i_redirect,
  input  logic [C_ADDR_W-1:0]  i_redirect_addr,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [C_INSTR_W-1:0] o_instr,
  output logic [C_ADDR_W-1:0]  o_instr_pc,
  output logic [15:0]          o_fetch_cnt,
  output logic [15:0]          o_flush_cnt
);

  localparam logic [DEPTH_LOG2+1:0] C_DEPTH = (DEPTH_LOG2+2)'(1 << DEPTH_LOG2);

  logic [C_ADDR_W-1:0]   r_pc;
  logic                  r_inflight;
  logic [C_ADDR_W-1:0]   r_inflight_pc;
  logic [DEPTH_LOG2:0]   w_count;
  logic [DEPTH_LOG2+1:0] w_used;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  ifu_entry_t            w_push_data;
  ifu_entry_t            w_head;

  // Credits count the inflight word so a capture can never find the FIFO full.
  assign w_used      = {1'b0, w_count} + {{(DEPTH_LOG2+1){1'b0}}, r_inflight};
  assign w_issue     = !i_redirect && (w_used < C_DEPTH);
  assign w_push      = r_inflight && !i_redirect;
  assign w_pop       = o_valid && i_ready;
  assign w_push_data = '{pc: r_inflight_pc, instr: i_rom_data};

  assign o_rom_addr  = r_pc;
  assign o_valid     = (w_count != '0);
  assign o_instr     = w_head.instr;
  assign o_instr_pc  = w_head.pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_VEC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (i_redirect) begin
      r_pc          <= i_redirect_addr;
      r_inflight    <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= next_pc(r_pc);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  ifu_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_count     (w_count),
    .o_head      (w_head)
  );

`ifdef IFU_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;
  logic [15:0] w_discard;

  // A same-cycle pop was accepted by the decoder, so it is not a discard.
  assign w_discard = 16'(w_count) + 16'(r_inflight) - 16'(w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
      if (i_redirect) begin
        r_flush_cnt <= r_flush_cnt + w_discard;
      end
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_fetch_cnt = 16'h0000;
  assign o_flush_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch_unit : directed bench with a 1-cycle registered ROM   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic [15:0] rom_q;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        valid;
  logic        ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;

  logic [15:0] mem [0:65535];
  int          n_vec;
  int          n_err;

  instr_fetch_unit dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_rom_addr      (rom_addr),
    .i_rom_data      (rom_q),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc),
    .o_fetch_cnt     (fetch_cnt),
    .o_flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 16'h0000;
    ready         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", valid); end
    n_vec++; if (rom_addr !== 16'h0000) begin n_err++; $display("FAIL rst_rom_addr got=%h exp=0000", rom_addr); end
    n_vec++; if (instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    n_vec++; if (instr_pc !== 16'h0000) begin n_err++; $display("FAIL rst_instr_pc got=%h exp=0000", instr_pc); end
    n_vec++; if (fetch_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_fetch_cnt got=%h exp=0000", fetch_cnt); end
    n_vec++; if (flush_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_flush_cnt got=%h exp=0000", flush_cnt); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] exp_w [4];
    exp_w = '{16'h8A00, 16'h8B01, 16'h8C02, 16'h8D03};
    do_reset();
    ready = 1'b1;
    tick();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL stream_lat1 valid got=%b exp=0", valid); end
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick(); else tick();
      n_vec++; if (valid !== 1'b1 || instr !== exp_w[k] || instr_pc !== 16'(k)) begin
        n_err++; $display("FAIL stream_w%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", k, valid, instr, instr_pc, exp_w[k], 16'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w [6];
    exp_w = '{16'h8A00, 16'h8B01, 16'h8C02, 16'h8D03, 16'h8E04, 16'h0001};
    do_reset();
    repeat (10) tick();
    n_vec++; if (rom_addr !== 16'h0004) begin n_err++; $display("FAIL bp_stall_addr got=%h exp=0004", rom_addr); end
    n_vec++; if (valid !== 1'b1 || instr !== 16'h8A00 || instr_pc !== 16'h0000) begin
      n_err++; $display("FAIL bp_hold got v=%b i=%h pc=%h exp v=1 i=8A00 pc=0000", valid, instr, instr_pc);
    end
    ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      n_vec++; if (valid !== 1'b1 || instr !== exp_w[k] || instr_pc !== 16'(k)) begin
        n_err++; $display("FAIL bp_drain%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", k, valid, instr, instr_pc, exp_w[k], 16'(k));
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_redirect_flush();
    do_reset();
    repeat (4) tick();
    redirect      = 1'b1;
    redirect_addr = 16'h0030;
    tick();
    redirect = 1'b0;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rd_valid got=%b exp=0", valid); end
    n_vec++; if (rom_addr !== 16'h0030) begin n_err++; $display("FAIL rd_rom_addr got=%h exp=0030", rom_addr); end
`ifdef IFU_PERF_CNT_EN
    n_vec++; if (flush_cnt !== 16'd4) begin n_err++; $display("FAIL rd_flush_cnt got=%0d exp=4", flush_cnt); end
    n_vec++; if (fetch_cnt !== 16'd3) begin n_err++; $display("FAIL rd_fetch_cnt got=%0d exp=3", fetch_cnt); end
`else
    n_vec++; if (flush_cnt !== 16'd0) begin n_err++; $display("FAIL rd_flush_cnt got=%0d exp=0", flush_cnt); end
`endif
    tick();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rd_lat1 valid got=%b exp=0", valid); end
    tick();
    n_vec++; if (valid !== 1'b1 || instr !== 16'hA530 || instr_pc !== 16'h0030) begin
      n_err++; $display("FAIL rd_first got v=%b i=%h pc=%h exp v=1 i=A530 pc=0030", valid, instr, instr_pc);
    end
    ready = 1'b1;
    tick();
    n_vec++; if (valid !== 1'b1 || instr !== 16'h0001 || instr_pc !== 16'h0031) begin
      n_err++; $display("FAIL rd_second got v=%b i=%h pc=%h exp v=1 i=0001 pc=0031", valid, instr, instr_pc);
    end
    ready = 1'b0;
  endtask

  task automatic test_redirect_pop();
    do_reset();
    tick();
    tick();
    ready         = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 16'h0040;
    n_vec++; if (valid !== 1'b1 || instr_pc !== 16'h0000) begin
      n_err++; $display("FAIL rp_accept got v=%b pc=%h exp v=1 pc=0000", valid, instr_pc);
    end
    tick();
    redirect = 1'b0;
    ready    = 1'b0;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rp_empty got=%b exp=0", valid); end
`ifdef IFU_PERF_CNT_EN
    n_vec++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL rp_flush_cnt got=%0d exp=1", flush_cnt); end
`endif
    tick();
    tick();
    n_vec++; if (valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== 16'h0001) begin
      n_err++; $display("FAIL rp_resume got v=%b i=%h pc=%h exp v=1 i=0001 pc=0040", valid, instr, instr_pc);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [15:0] exp_pc [4];
    logic [15:0] exp_w  [4];
    exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_w  = '{16'hC0FE, 16'hC1FF, 16'h8A00, 16'h8B01};
    do_reset();
    ready = 1'b1;
    tick();
    redirect      = 1'b1;
    redirect_addr = 16'h0100;
    tick();
    redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    n_vec++; if (rom_addr !== 16'hFFFE || valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_target got addr=%h v=%b exp addr=FFFE v=0", rom_addr, valid);
    end
`ifdef IFU_PERF_CNT_EN
    n_vec++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL b2b_flush_cnt got=%0d exp=1", flush_cnt); end
`endif
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if (valid !== 1'b1 || instr !== exp_w[k] || instr_pc !== exp_pc[k]) begin
        n_err++; $display("FAIL wrap%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", k, valid, instr, instr_pc, exp_w[k], exp_pc[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1'b1;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got=%b exp=0", valid); end
    n_vec++; if (rom_addr !== 16'h0000) begin n_err++; $display("FAIL ar_rom_addr got=%h exp=0000", rom_addr); end
    n_vec++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin
      n_err++; $display("FAIL ar_head got i=%h pc=%h exp i=0000 pc=0000", instr, instr_pc);
    end
    n_vec++; if (fetch_cnt !== 16'h0000) begin n_err++; $display("FAIL ar_fetch_cnt got=%h exp=0000", fetch_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ar_lat1 got=%b exp=0", valid); end
    tick();
    n_vec++; if (valid !== 1'b1 || instr !== 16'h8A00 || instr_pc !== 16'h0000) begin
      n_err++; $display("FAIL ar_refetch0 got v=%b i=%h pc=%h exp v=1 i=8A00 pc=0000", valid, instr, instr_pc);
    end
    tick();
    n_vec++; if (valid !== 1'b1 || instr !== 16'h8B01 || instr_pc !== 16'h0001) begin
      n_err++; $display("FAIL ar_refetch1 got v=%b i=%h pc=%h exp v=1 i=8B01 pc=0001", valid, instr, instr_pc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0001;
    mem[16'h0000] = 16'h8A00;
    mem[16'h0001] = 16'h8B01;
    mem[16'h0002] = 16'h8C02;
    mem[16'h0003] = 16'h8D03;
    mem[16'h0004] = 16'h8E04;
    mem[16'h0030] = 16'hA530;
    mem[16'hFFFE] = 16'hC0FE;
    mem[16'hFFFF] = 16'hC1FF;
    rst_n         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 16'h0000;
    ready         = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_pop();
    test_back_to_back_wrap();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
